// File: rtl/acondicionador_botones.sv
// rtl/acondicionador_botones.sv - button conditioner: sync, debounce, press pulse, auto-repeat
module acondicionador_botones #(
  parameter int                N_BTN           = 5,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                REPEAT_DELAY    = 25000000,
  parameter int                REPEAT_RATE     = 5000000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 5'b00011,
  parameter int                CNT_W           = 25
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, REPEAT} rep_state_t;

  logic [N_BTN-1:0] s1, s2;

  always_ff @(posedge Clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] dcnt, dcnt_d, rcnt, rcnt_d;
    logic             level_q, level_d, pulse_q, fire;
    rep_state_t       state, state_d;

    always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      if (s2[i] != level_q) begin
        if (dcnt == DB_LAST) level_d = s2[i];
        else                 dcnt_d  = dcnt + 1'b1;
      end
    end

    // Decisions use the next level so a release wins over a coinciding repeat.
    always_comb begin
      state_d = state;
      rcnt_d  = rcnt;
      fire    = 1'b0;
      if (!REPEAT_MASK[i] || !level_d) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else begin
        case (state)
          IDLE: begin
            state_d = WAIT_FIRST;
            rcnt_d  = '0;
          end
          WAIT_FIRST: begin
            if (rcnt == RD_LAST) begin
              fire    = 1'b1;
              rcnt_d  = '0;
              state_d = REPEAT;
            end else begin
              rcnt_d = rcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt == RR_LAST) begin
              fire   = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge Clock) begin
      if (reset) begin
        dcnt    <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        rcnt    <= '0;
        state   <= IDLE;
      end else begin
        dcnt    <= dcnt_d;
        level_q <= level_d;
        pulse_q <= (level_d & ~level_q) | fire;
        rcnt    <= rcnt_d;
        state   <= state_d;
      end
    end

    assign level[i] = level_q;
    assign pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_acondicionador_botones.sv
// tb/tb_acondicionador_botones.sv - scoreboard bench for acondicionador_botones
module tb_acondicionador_botones;

  logic       Clock = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] level;
  logic [4:0] pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [4:0] v;
  } ev_t;

  ev_t pq[$];
  ev_t lq[$];

  acondicionador_botones #(
    .N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3),
    .REPEAT_MASK(5'b00011), .CNT_W(25)
  ) dut (
    .Clock(Clock), .reset(reset), .btn_raw(btn_raw), .level(level), .pulse(pulse)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic exp_pulse(input int c, input logic [4:0] v);
    int k = 0;
    while (k < pq.size() && pq[k].c <= c) k++;
    pq.insert(k, '{c, v});
  endtask

  task automatic exp_level(input int c, input logic [4:0] v);
    int k = 0;
    while (k < lq.size() && lq[k].c <= c) k++;
    lq.insert(k, '{c, v});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge Clock) begin
    ev_t e;
    while (pq.size() > 0 && pq[0].c < cyc) begin
      e = pq.pop_front();
      checks++; errors++;
      $display("FAIL pulse_missed cyc=%0d want %b", e.c, e.v);
    end
    if (pq.size() > 0 && pq[0].c == cyc) begin
      e = pq.pop_front();
      checks++;
      if (pulse !== e.v) begin
        errors++;
        $display("FAIL pulse cyc=%0d got %b want %b", cyc, pulse, e.v);
      end
    end else if (pulse !== 5'b0) begin
      checks++; errors++;
      $display("FAIL pulse_unexpected cyc=%0d got %b want 00000", cyc, pulse);
    end
    while (lq.size() > 0 && lq[0].c < cyc) begin
      e = lq.pop_front();
      checks++; errors++;
      $display("FAIL level_missed cyc=%0d want %b", e.c, e.v);
    end
    if (lq.size() > 0 && lq[0].c == cyc) begin
      e = lq.pop_front();
      checks++;
      if (level !== e.v) begin
        errors++;
        $display("FAIL level cyc=%0d got %b want %b", cyc, level, e.v);
      end
    end
  end

  initial begin
    int t0;
    reset   = 1'b1;
    btn_raw = 5'b11111;

    // all held through reset, then fresh press of every channel
    exp_level(1, 5'b0); exp_level(2, 5'b0); exp_level(3, 5'b0);
    wait_cyc(3);
    reset = 1'b0;
    t0 = cyc;
    exp_level(t0 + 5, 5'b00000);
    exp_level(t0 + 6, 5'b11111);
    exp_pulse(t0 + 6, 5'b11111);
    wait_cyc(6);
    btn_raw = 5'b0;
    t0 = cyc;
    exp_level(t0 + 5, 5'b11111);
    exp_level(t0 + 6, 5'b00000);
    wait_cyc(10);

    // Tono: no auto-repeat
    t0 = cyc;
    btn_raw = 5'b00100;
    exp_level(t0 + 5, 5'b00000);
    exp_level(t0 + 6, 5'b00100);
    exp_pulse(t0 + 6, 5'b00100);
    exp_level(t0 + 20, 5'b00100);
    wait_cyc(20);
    btn_raw = 5'b0;
    exp_level(t0 + 26, 5'b00000);
    wait_cyc(10);

    // color: glitches one cycle short of the debounce window
    for (int g = 0; g < 4; g++) begin
      t0 = cyc;
      btn_raw = 5'b01000;
      exp_level(t0 + 5, 5'b0);
      wait_cyc(3);
      btn_raw = 5'b0;
      wait_cyc(3);
    end
    exp_level(cyc + 1, 5'b0);
    exp_level(cyc + 6, 5'b0);
    wait_cyc(8);

    // Up held: press then repeats
    t0 = cyc;
    btn_raw = 5'b00001;
    exp_pulse(t0 + 6, 5'b00001);
    for (int k = 0; k < 7; k++) exp_pulse(t0 + 16 + 3 * k, 5'b00001);
    exp_level(t0 + 35, 5'b00001);
    exp_level(t0 + 36, 5'b00000);
    wait_cyc(30);
    btn_raw = 5'b0;
    wait_cyc(10);

    // Down released exactly when a repeat would fire
    t0 = cyc;
    btn_raw = 5'b00010;
    exp_pulse(t0 + 6,  5'b00010);
    exp_pulse(t0 + 16, 5'b00010);
    exp_pulse(t0 + 19, 5'b00010);
    exp_level(t0 + 21, 5'b00010);
    exp_level(t0 + 22, 5'b00000);
    wait_cyc(16);
    btn_raw = 5'b0;
    wait_cyc(14);
    t0 = cyc;
    btn_raw = 5'b00010;
    exp_pulse(t0 + 6,  5'b00010);
    exp_pulse(t0 + 16, 5'b00010);
    wait_cyc(12);
    btn_raw = 5'b0;
    exp_level(t0 + 18, 5'b00000);
    wait_cyc(10);

    // Up and Lp together: one shared press pulse, only Up repeats
    t0 = cyc;
    btn_raw = 5'b10001;
    exp_pulse(t0 + 6,  5'b10001);
    exp_level(t0 + 6,  5'b10001);
    exp_pulse(t0 + 16, 5'b00001);
    wait_cyc(12);
    btn_raw = 5'b0;
    exp_level(t0 + 18, 5'b00000);
    wait_cyc(10);

    // reset while held: cleared, then a fresh press
    t0 = cyc;
    btn_raw = 5'b00100;
    exp_pulse(t0 + 6, 5'b00100);
    exp_level(t0 + 10, 5'b00100);
    wait_cyc(10);
    reset = 1'b1;
    exp_level(t0 + 11, 5'b0);
    exp_level(t0 + 12, 5'b0);
    wait_cyc(2);
    reset = 1'b0;
    exp_level(t0 + 17, 5'b0);
    exp_level(t0 + 18, 5'b00100);
    exp_pulse(t0 + 18, 5'b00100);
    wait_cyc(6);
    btn_raw = 5'b0;
    exp_level(t0 + 24, 5'b0);
    wait_cyc(10);

    while (pq.size() > 0) begin
      ev_t e = pq.pop_front();
      checks++; errors++;
      $display("FAIL pulse_pending cyc=%0d want %b", e.c, e.v);
    end
    while (lq.size() > 0) begin
      ev_t e = lq.pop_front();
      checks++; errors++;
      $display("FAIL level_pending cyc=%0d want %b", e.c, e.v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
